// File: rtl/legv8_bus_initiator_pkg.sv
// Shared definitions for the LEGv8 peripheral-bus initiator: FSM states,
// GPIO address map and parameter limits.
package legv8_bus_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_TURN  = 2'd3
  } bus_state_e;

  localparam logic [63:0] GPIO_OUT = 64'h0;
  localparam logic [63:0] GPIO_DIR = 64'h1;
  localparam logic [63:0] GPIO_IN  = 64'h2;

  localparam int unsigned CNT_W           = 4;
  localparam int unsigned WAIT_STATES_MAX = 15;
  localparam int unsigned TURNAROUND_MAX  = 3;

endpackage

// File: rtl/legv8_bus_initiator_if.sv
// Request/response handshake and bus strobes between the memory stage,
// the initiator and the bus responders (tri-state data travels separately).
interface legv8_bus_initiator_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;
  logic [ADDR_W-1:0] address;
  logic              write;
  logic              read;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy, address, write, read
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy, address, write, read
  );
endinterface

// File: rtl/legv8_bus_initiator_bus_wait_counter.sv
// Loadable down-counter with zero flag; times both read wait states and
// post-read turnaround. Saturates at zero.
module bus_wait_counter
  import legv8_bus_initiator_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);
endmodule

// File: rtl/legv8_bus_initiator.sv
// LEGv8 bus initiator: accepts one load/store at a time and runs a registered
// bus cycle with configurable read wait states and turnaround.
module legv8_bus_initiator
  import legv8_bus_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TURNAROUND  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  legv8_bus_initiator_if.master bus,
  inout  wire  [DATA_W-1:0]     data
);
  localparam int unsigned W_EFF = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
  localparam int unsigned T_EFF = (TURNAROUND > TURNAROUND_MAX) ? TURNAROUND_MAX : TURNAROUND;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(W_EFF);
  // The counter reaches zero in the last TURN cycle, hence T-1.
  localparam logic [CNT_W-1:0] TURN_LD = (T_EFF == 0) ? '0 : CNT_W'(T_EFF - 1);

  bus_state_e        r_state;
  bus_state_e        w_next_state;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_wdata;
  logic              r_write;
  logic              r_read;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_accept;
  logic              w_sample;
  logic              w_bus_done;
  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_value;
  logic              w_cnt_dec;
  logic              w_cnt_zero;

  bus_wait_counter u_wait_counter (
    .clock   (clock),
    .reset   (reset),
    .i_load  (w_cnt_load),
    .i_value (w_cnt_value),
    .i_dec   (w_cnt_dec),
    .o_zero  (w_cnt_zero)
  );

  assign bus.req_ready = (r_state == ST_IDLE) & reset;
  assign w_accept      = bus.req_valid & bus.req_ready;

  always_comb begin
    w_next_state = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_value  = '0;
    w_cnt_dec    = 1'b0;
    w_sample     = 1'b0;
    w_bus_done   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.req_write) begin
            w_next_state = ST_WRITE;
          end else begin
            w_next_state = ST_READ;
            w_cnt_load   = 1'b1;
            w_cnt_value  = WAIT_LD;
          end
        end
      end
      ST_WRITE: begin
        w_next_state = ST_IDLE;
        w_bus_done   = 1'b1;
      end
      ST_READ: begin
        if (w_cnt_zero) begin
          w_sample   = 1'b1;
          w_bus_done = 1'b1;
          if (T_EFF == 0) begin
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_TURN;
            w_cnt_load   = 1'b1;
            w_cnt_value  = TURN_LD;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_TURN: begin
        if (w_cnt_zero) begin
          w_next_state = ST_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Strobes and address are loaded on accept and cleared as the bus cycle
  // closes, so they are registered copies of the WRITE/READ state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_address   <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_next_state;
      r_rsp_valid <= w_bus_done;
      if (w_sample) begin
        r_rsp_rdata <= data;
      end
      if (w_accept) begin
        r_address <= bus.req_addr;
        r_wdata   <= bus.req_wdata;
        r_write   <= bus.req_write;
        r_read    <= ~bus.req_write;
      end else if (w_bus_done) begin
        r_address <= '0;
        r_write   <= 1'b0;
        r_read    <= 1'b0;
      end
    end
  end

  assign data          = r_write ? r_wdata : 'z;
  assign bus.address   = r_address;
  assign bus.write     = r_write;
  assign bus.read      = r_read;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.busy      = (r_state != ST_IDLE);
endmodule

// File: doc/legv8_bus_initiator.md
# legv8_bus_initiator

Initiator side of the LEGv8 memory-mapped peripheral bus. Sits between the processor's memory stage and the shared `address`/`data`/`read`/`write` bus that GPIO and other responders decode. It accepts one load/store request at a time over a valid/ready handshake and runs the bus cycle with configurable read wait states and turnaround. It returns read data with a one-cycle response pulse.

## Interface
- `ADDR_W`, 64, bus address width
- `DATA_W`, 64, bus data width
- `WAIT_STATES`, 0, extra cycles `read` is held before data is sampled (0..15)
- `TURNAROUND`, 1, idle cycles after a read before the next bus cycle (0..3)

- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `req_valid`  in  1  memory stage has a request
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  ADDR_W  target address
- `req_wdata`  in  DATA_W  store data
- `req_ready`  out  1  initiator can accept a request
- `rsp_valid`  out  1  one-cycle completion pulse for both loads and stores
- `rsp_rdata`  out  DATA_W  load data; holds its value until the next load completes
- `busy`  out  1  the FSM is not in IDLE
- `address`  out  ADDR_W  bus address
- `data`  inout  DATA_W  bus data; driven only during a write
- `write`  out  1  bus write strobe
- `read`  out  1  bus read strobe

## Operation
- The FSM has four states: IDLE, WRITE, READ and TURN.
- `req_ready` = (state == IDLE) & `reset`.
- A request is accepted on an edge where `req_valid` & `req_ready` are both high. At that edge `req_write`, `req_addr` and `req_wdata` are captured into internal registers.
- **IDLE:**
  - On accept with `req_write` = 1, go to WRITE.
  - On accept with `req_write` = 0, load the wait counter with `WAIT_STATES` and go to READ.
- **WRITE** lasts exactly one cycle:
  - `address` = captured address, `data` = captured wdata, `write` = 1.
  - Then go to IDLE and assert `rsp_valid` for one cycle.
- **READ:**
  - `address` = captured address, `read` = 1.
  - The counter decrements each cycle.
  - On the cycle the counter reaches 0, `data` is sampled into `rsp_rdata` at the closing edge.
  - Then go to TURN, or to IDLE if `TURNAROUND` = 0, and assert `rsp_valid` for one cycle.
- **TURN:** all strobes are 0 and `data` is hi-Z for `TURNAROUND` cycles, then go to IDLE.
- Outside WRITE and READ: `address` = 0, `write` = 0, `read` = 0.
- Outside WRITE, `data` is hi-Z at all times.
- `read` and `write` are never high together.
- A `req_valid` that arrives while busy is not accepted. The requester must hold it until `req_ready` is high.
- Stores do not modify `rsp_rdata`.

## Timing
- All outputs are registered except `req_ready`.
- Reset values: `address` 0, `write` 0, `read` 0, `data` hi-Z, `rsp_valid` 0, `rsp_rdata` 0, `busy` 0, state IDLE.
- Store accepted at edge ending cycle N:
  - `write` high in cycle N+1.
  - `rsp_valid` and `req_ready` high in cycle N+2.
- Load accepted at edge ending cycle N, with W = `WAIT_STATES` and T = `TURNAROUND`:
  - `read` high in cycles N+1 .. N+1+W.
  - Data sampled at the edge ending cycle N+1+W.
  - `rsp_valid` high in cycle N+2+W.
  - `req_ready` high in cycle N+2+W+T.
- Back-to-back: a request presented in the `rsp_valid` cycle of a store is accepted in that same cycle, giving a bus cycle every 2 clocks.
- Reset low mid-operation:
  - At the next edge, strobes drop, `data` releases, and the state returns to IDLE.
  - No `rsp_valid` is issued for the aborted access.
  - `rsp_rdata` clears to 0.
- A `req_valid` coincident with reset low is ignored.

## Structure
- Shared package holds:
  - state encoding constants;
  - bus address-map constants: GPIO_OUT = 64'h0, GPIO_DIR = 64'h1, GPIO_IN = 64'h2;
  - parameter range limits.
- One sub-module is natural: `bus_wait_counter`, a loadable 4-bit down-counter with a zero flag, used for both READ wait states and TURN.

## Test plan
- **Store:** store 64'h5A to GPIO_DIR with the GPIO responder attached -> `write` is high for exactly 1 cycle, `data` = 64'h5A in that cycle, `rsp_valid` pulses in the next cycle, and DIR reads back 64'h5A.
- **Load with wait states:** with `WAIT_STATES` = 2 and the responder driving 64'hDEAD_BEEF -> `read` is high for 3 cycles, then `rsp_valid` with `rsp_rdata` = 64'hDEAD_BEEF, then `req_ready` low for 1 TURN cycle.
- **Back-to-back stores:** 4 stores with `req_valid` held high -> accepted every 2 cycles, 4 `rsp_valid` pulses, and `read` never asserted.
- **Request while busy:** a request during READ -> not accepted until IDLE, and the address of the in-flight load is unchanged.
- **Reset mid-read:** reset low in the 2nd READ cycle -> `read` = 0 and `data` hi-Z at the next edge, no `rsp_valid`, `rsp_rdata` = 0, and the FSM is in IDLE after reset releases.
- **Minimum timing:** with `WAIT_STATES` = 0 and `TURNAROUND` = 0, a load then a store -> `read` lasts 1 cycle, `req_ready` returns in the `rsp_valid` cycle, and `write` and `read` never overlap.
